icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Instruction cache answering the fetch pipeline: a fetch address is presented in IF0 and
//  the instruction is returned in IF1. Two-way set-associative, read-only, true-LRU per set.
//  Misses refill one whole line from the memory-side burst read port.
//  While a miss is outstanding, inst_ready=0 stalls IF0 and flushes IF1_ID.
// PARAMETERS
//  INDEX_BITS   6   set index width (64 sets)
//  OFFSET_BITS  2   log2 words per line (4 words = 16 B)
//  TAG_BITS     32-INDEX_BITS-OFFSET_BITS-2   tag width, derived (localparam)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous reset, active-low
//  req_valid     in   1   IF0 fetch request valid
//  req_addr      in   32  IF0 fetch PC, word aligned ([1:0] ignored)
//  req_cancel    in   1   EX branch redirect: drop response for outstanding request
//  inst_valid    out  1   IF1 instruction valid this cycle
//  inst_ready    out  1   cache can accept a new request this cycle (0 = stall IF0)
//  inst_data     out  32  instruction for the outstanding request
//  mem_rd_req    out  1   refill request, held high until mem_rd_gnt
//  mem_rd_addr   out  32  line-aligned refill address ([OFFSET_BITS+1:0] = 0)
//  mem_rd_gnt    in   1   memory accepts refill request
//  mem_rd_valid  in   1   refill data beat valid
//  mem_rd_data   in   32  refill data, ascending word order
//  mem_rd_last   in   1   final beat of the line
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): all valid bits and LRU bits cleared, FSM=LOOKUP,
//    no outstanding request; inst_valid=0, inst_ready=1, inst_data=0, mem_rd_req=0,
//    mem_rd_addr=0. Reset mid-refill abandons the line: no way is written, and the
//    remaining memory beats are ignored.
//  - Accept: a request is accepted at the edge where req_valid=1 and inst_ready=1. The
//    address is latched, and tag/data RAMs are read synchronously with index req_addr.
//  - LOOKUP, hit (either way's valid bit set and its tag matches the latched tag), one cycle
//    after accept: inst_valid=1, inst_data=word[offset], inst_ready=1 (back-to-back fetch).
//    LRU is updated to point at the other way.
//  - LOOKUP, miss: inst_valid=0 and inst_ready=0 in the same cycle. FSM -> MISS.
//  - MISS: mem_rd_req=1 with mem_rd_addr={tag,index,0}. At mem_rd_gnt -> REFILL.
//  - REFILL: each beat with mem_rd_valid is written to a line buffer. The beat counter
//    wraps at 2^OFFSET_BITS. At the beat with mem_rd_last, the victim way is written:
//    the invalid way if any (way0 preferred), else the LRU way. Its tag is written and its
//    valid bit set. FSM -> DONE.
//  - DONE (1 cycle): inst_valid=1 (unless cancelled), inst_data=buffer[offset],
//    inst_ready=1, LRU is updated, and a new request may be accepted. FSM -> LOOKUP.
//  - mem_rd_last arriving before 2^OFFSET_BITS beats is a protocol error; the line is
//    written as received.
//  - req_cancel=1 with an outstanding request: the response is suppressed (inst_valid=0).
//    An in-flight refill still completes and fills the line.
//  - req_cancel and an accept in the same cycle: the cancel applies to the old request only.
//  - Only one miss is outstanding at a time. While FSM!=LOOKUP, req_addr is ignored.
//  - Latencies: hit = 1 cycle. Miss = 1 + grant wait + beats + 1 (DONE).
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
//    Each counts accepted lookups, excluding cancelled ones; both wrap silently at 2^32
//    and reset to 0. A miss is counted when FSM enters MISS.
//  Undefined: these ports and their counters do not exist; all other behaviour is identical.
// TESTING
//  1. Cold miss: reset, req 0x0000_0104 -> mem_rd_req with addr 0x100; 4 beats
//     0xA0..0xA3 -> DONE, inst_data=0xA1.
//  2. Hit stream: after test 1, req 0x100,0x104,0x108,0x10C on back-to-back cycles
//     -> inst_valid every cycle, data 0xA0..0xA3, inst_ready stays 1.
//  3. LRU: fill addrs 0x100 and 0x1100 (same set), touch 0x100, miss 0x2100
//     -> 0x1100's way replaced; 0x100 still hits.
//  4. Cancel: miss on 0x200, req_cancel during REFILL -> no inst_valid in DONE;
//     a later 0x200 request hits.
//  5. Reset mid-refill after 2 beats -> outputs at reset values; 0x100 then misses.
//  6. ICACHE_STATS_EN: run tests 1-2 -> stat_misses=1, stat_hits=4.

Source files
------------

// File: rtl/icache_responder.sv
// icache_responder: 2-way set-associative, read-only instruction cache with
// true-LRU replacement and whole-line burst refill from a memory read port.
// Optional macro ICACHE_STATS_EN adds the stat_hits / stat_misses counters.
module icache_responder #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        req_cancel,
  output logic        inst_valid,
  output logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int WA       = INDEX_BITS + OFFSET_BITS;

  typedef enum logic [1:0] {S_LOOKUP, S_MISS, S_REFILL, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_pending;    // a lookup result is due this cycle
  logic                   r_cancelled;  // outstanding miss response is dropped
  logic                   r_victim;
  logic [29:0]            r_addr;       // latched word address (PC[31:2])
  logic [SETS-1:0]        r_lru;        // per set: index of least-recently-used way
  logic [OFFSET_BITS-1:0] r_beat;
  logic [31:0]            r_line_buf [WORDS];
  logic                   r_mem_rd_req;
  logic [31:0]            r_mem_rd_addr;

  logic [OFFSET_BITS-1:0] w_off;
  logic [INDEX_BITS-1:0]  w_idx;
  logic [TAG_BITS-1:0]    w_tag;
  logic [INDEX_BITS-1:0]  w_req_idx;
  logic [WA-1:0]          w_req_word;
  logic [1:0]             w_way_hit;
  logic [1:0]             w_way_vld;
  logic [31:0]            w_way_data [2];
  logic                   w_hit;
  logic                   w_hit_way;
  logic                   w_victim;
  logic                   w_accept;
  logic                   w_beat_we;
  logic                   w_line_done;
  logic                   w_lookup_due;

  assign w_off      = r_addr[OFFSET_BITS-1:0];
  assign w_idx      = r_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_tag      = r_addr[WA +: TAG_BITS];
  assign w_req_idx  = req_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign w_req_word = req_addr[2 +: WA];

  assign w_hit        = |w_way_hit;
  assign w_hit_way    = w_way_hit[1];
  assign w_lookup_due = (r_state == S_LOOKUP) && r_pending;
  // Prefer an empty way (way0 first) before evicting the LRU one
  assign w_victim     = !w_way_vld[0] ? 1'b0 : (!w_way_vld[1] ? 1'b1 : r_lru[w_idx]);

  assign inst_ready  = (r_state == S_DONE) || ((r_state == S_LOOKUP) && !(r_pending && !w_hit));
  assign w_accept    = req_valid && inst_ready;
  // Beats are written straight into the victim way; reset gates the write so an
  // abandoned refill never lands, and lookups cannot happen during REFILL anyway.
  assign w_beat_we   = rst && (r_state == S_REFILL) && mem_rd_valid;
  assign w_line_done = w_beat_we && mem_rd_last;

  assign inst_valid  = (w_lookup_due && w_hit && !req_cancel) ||
                       ((r_state == S_DONE) && !r_cancelled && !req_cancel);
  assign inst_data   = (r_state == S_DONE) ? r_line_buf[w_off] :
                       (w_lookup_due && w_hit) ? w_way_data[w_hit_way] : 32'h0;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_rd_addr = r_mem_rd_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      localparam bit WAY = (gi == 1);
      logic [TAG_BITS-1:0] r_tag_ram  [SETS];
      logic [31:0]         r_data_ram [SETS*WORDS];
      logic [TAG_BITS-1:0] r_tag_rd;
      logic [31:0]         r_data_rd;
      logic [SETS-1:0]     r_valid;
      logic                w_sel;

      assign w_sel = (r_victim == WAY);

      // Tag/data RAMs: refill writes into the victim way, registered read at accept
      always_ff @(posedge clk) begin
        if (w_beat_we && w_sel) r_data_ram[{w_idx, r_beat}] <= mem_rd_data;
        if (w_line_done && w_sel) r_tag_ram[w_idx] <= w_tag;
        if (w_accept) begin
          r_tag_rd  <= r_tag_ram[w_req_idx];
          r_data_rd <= r_data_ram[w_req_word];
        end
      end

      // Valid bits: cleared by reset, set when the victim line completes
      always_ff @(posedge clk) begin
        if (!rst) r_valid <= '0;
        else if (w_line_done && w_sel) r_valid[w_idx] <= 1'b1;
      end

      assign w_way_vld[gi]  = r_valid[w_idx];
      assign w_way_hit[gi]  = r_valid[w_idx] && (r_tag_rd == w_tag);
      assign w_way_data[gi] = r_data_rd;
    end
  endgenerate

  // Line buffer captures the refill so DONE can answer without a RAM read
  always_ff @(posedge clk) begin
    if (w_beat_we) r_line_buf[r_beat] <= mem_rd_data;
  end

  // Control FSM: lookup, miss request, refill beats, one-cycle response
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_LOOKUP;
      r_pending     <= 1'b0;
      r_cancelled   <= 1'b0;
      r_victim      <= 1'b0;
      r_addr        <= '0;
      r_lru         <= '0;
      r_beat        <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= '0;
    end else begin
      r_pending <= w_accept;
      if (w_accept) r_addr <= req_addr[31:2];
      case (r_state)
        S_LOOKUP: begin
          if (r_pending) begin
            if (w_hit) begin
              r_lru[w_idx] <= ~w_hit_way;
            end else begin
              r_state       <= S_MISS;
              r_victim      <= w_victim;
              r_cancelled   <= req_cancel;
              r_mem_rd_req  <= 1'b1;
              r_mem_rd_addr <= {w_tag, w_idx, {(OFFSET_BITS+2){1'b0}}};
            end
          end
        end
        S_MISS: begin
          if (req_cancel) r_cancelled <= 1'b1;
          if (mem_rd_gnt) begin
            r_state      <= S_REFILL;
            r_mem_rd_req <= 1'b0;
            r_beat       <= '0;
          end
        end
        S_REFILL: begin
          if (req_cancel) r_cancelled <= 1'b1;
          if (mem_rd_valid) begin
            r_beat <= r_beat + 1'b1;
            if (mem_rd_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_lru[w_idx] <= ~r_victim;
          r_state      <= S_LOOKUP;
        end
        default: r_state <= S_LOOKUP;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  // Count uncancelled lookups; a miss counts on the cycle the FSM enters MISS
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (w_lookup_due && !req_cancel) begin
      if (w_hit) r_stat_hits   <= r_stat_hits + 32'd1;
      else       r_stat_misses <= r_stat_misses + 32'd1;
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hit stream, LRU replacement,
// cancel during refill, short line, and reset in the middle of a refill.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_cancel;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_last;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;
  vec_t hit_vec [4];

  icache_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_cancel(req_cancel),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst_ready"}, {31'd0, inst_ready}, 32'd1);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_mem_rd_req"}, {31'd0, mem_rd_req}, 32'd0);
    chk({tag, "_mem_rd_addr"}, mem_rd_addr, 32'd0);
  endtask

  // Single fetch expected to hit: result appears the cycle after accept
  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp_data);
    req_addr  = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    $display("fetch 0x%08h -> valid=%0b data=0x%08h", addr, inst_valid, inst_data);
    chk("hit_valid", {31'd0, inst_valid}, 32'd1);
    chk("hit_data", inst_data, exp_data);
    chk("hit_ready", {31'd0, inst_ready}, 32'd1);
  endtask

  // Full miss: lookup miss, request/grant, nbeats beats of base+i, DONE response
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] line,
                           input logic [31:0] base, input int nbeats, input int gnt_wait,
                           input logic [31:0] exp_word, input bit cancel);
    req_addr  = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("miss_lookup_valid", {31'd0, inst_valid}, 32'd0);
    chk("miss_lookup_ready", {31'd0, inst_ready}, 32'd0);
    tick();
    chk("miss_req", {31'd0, mem_rd_req}, 32'd1);
    chk("miss_addr", mem_rd_addr, line);
    repeat (gnt_wait) tick();
    chk("miss_req_held", {31'd0, mem_rd_req}, 32'd1);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    chk("req_dropped_after_gnt", {31'd0, mem_rd_req}, 32'd0);
    for (int b = 0; b < nbeats; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 32'(b);
      mem_rd_last  = (b == nbeats - 1);
      if (cancel && b == 1) req_cancel = 1'b1;
      chk("refill_no_valid", {31'd0, inst_valid}, 32'd0);
      tick();
      req_cancel = 1'b0;
    end
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    $display("refill 0x%08h beats=%0d cancel=%0b -> valid=%0b data=0x%08h",
             line, nbeats, cancel, inst_valid, inst_data);
    chk("done_valid", {31'd0, inst_valid}, cancel ? 32'd0 : 32'd1);
    if (!cancel) chk("done_data", inst_data, exp_word);
    chk("done_ready", {31'd0, inst_ready}, 32'd1);
    tick();
    chk("idle_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    hit_vec[0] = '{addr: 32'h0000_0100, exp_valid: 1'b1, exp_data: 32'h0000_00A0};
    hit_vec[1] = '{addr: 32'h0000_0104, exp_valid: 1'b1, exp_data: 32'h0000_00A1};
    hit_vec[2] = '{addr: 32'h0000_0108, exp_valid: 1'b1, exp_data: 32'h0000_00A2};
    hit_vec[3] = '{addr: 32'h0000_010C, exp_valid: 1'b1, exp_data: 32'h0000_00A3};

    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_cancel = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_rd_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_reset_outputs("reset");

    // Cold miss on 0x104 with a two-cycle grant wait
    miss_fill(32'h0000_0104, 32'h0000_0100, 32'h0000_00A0, 4, 2, 32'h0000_00A1, 1'b0);

    // Back-to-back hit stream from the table
    for (int i = 0; i < 4; i++) begin
      req_addr  = hit_vec[i].addr;
      req_valid = 1'b1;
      tick();
      $display("stream 0x%08h -> valid=%0b data=0x%08h ready=%0b",
               hit_vec[i].addr, inst_valid, inst_data, inst_ready);
      chk("stream_valid", {31'd0, inst_valid}, {31'd0, hit_vec[i].exp_valid});
      chk("stream_data", inst_data, hit_vec[i].exp_data);
      chk("stream_ready", {31'd0, inst_ready}, 32'd1);
    end
    req_valid = 1'b0;
    tick();
    chk("stream_end_valid", {31'd0, inst_valid}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stat_misses", stat_misses, 32'd1);
    chk("stat_hits", stat_hits, 32'd4);
`endif

    // LRU: fill second way, touch 0x100, then 0x2100 must evict 0x1100
    miss_fill(32'h0000_1100, 32'h0000_1100, 32'h0000_00B0, 4, 0, 32'h0000_00B0, 1'b0);
    fetch_hit(32'h0000_0100, 32'h0000_00A0);
    miss_fill(32'h0000_2100, 32'h0000_2100, 32'h0000_00C0, 4, 1, 32'h0000_00C0, 1'b0);
    fetch_hit(32'h0000_0100, 32'h0000_00A0);
    fetch_hit(32'h0000_2108, 32'h0000_00C2);
    miss_fill(32'h0000_1100, 32'h0000_1100, 32'h0000_00B8, 4, 0, 32'h0000_00B8, 1'b0);

    // Cancel during refill: no response, but the line is still filled
    miss_fill(32'h0000_0200, 32'h0000_0200, 32'h0000_00D0, 4, 0, 32'h0000_00D0, 1'b1);
    fetch_hit(32'h0000_0200, 32'h0000_00D0);
    fetch_hit(32'h0000_020C, 32'h0000_00D3);

    // Short line: last after 2 beats, the received words are usable
    miss_fill(32'h0000_0404, 32'h0000_0400, 32'h0000_00E0, 2, 0, 32'h0000_00E1, 1'b0);
    fetch_hit(32'h0000_0400, 32'h0000_00E0);

    // Reset after two refill beats of 0x300
    req_addr = 32'h0000_0300;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid_req", {31'd0, mem_rd_req}, 32'd1);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'h0000_00F0 + 32'(b);
      tick();
    end
    mem_rd_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset_outputs("rst_mid");
    for (int b = 2; b < 4; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'h0000_00F0 + 32'(b);
      mem_rd_last  = (b == 3);
      tick();
      chk("stray_beat_valid", {31'd0, inst_valid}, 32'd0);
      chk("stray_beat_req", {31'd0, mem_rd_req}, 32'd0);
    end
    mem_rd_valid = 1'b0;
    mem_rd_last  = 1'b0;
    miss_fill(32'h0000_0100, 32'h0000_0100, 32'h0000_0010, 4, 0, 32'h0000_0010, 1'b0);
    miss_fill(32'h0000_0308, 32'h0000_0300, 32'h0000_0020, 4, 0, 32'h0000_0022, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
